// File: rtl/ram_burst_master.sv
// ram_burst_master: burst initiator for a 16x8 sync dual-port RAM; define RAM_MASTER_CLEAR_EN to add clr_req and a CLEAR state
module ram_burst_master #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef RAM_MASTER_CLEAR_EN
  input  logic              clr_req,
`endif
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              ram_reset,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_w_add,
  output logic [ADDR_W-1:0] ram_r_add,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);
`ifdef RAM_MASTER_CLEAR_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
`endif
  localparam logic [ADDR_W:0] l_one = 1;
  state_t state_q, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [ADDR_W:0] left_q, left_n;
  logic [1:0] occ, occ_n;
  logic [2:0] pend;
  logic [DATA_W-1:0] s1;
  logic re_d1, wd_hs, pop, push, issue, done_d, clr_d;
  assign wd_hs = wd_valid & wd_ready;
  assign pop = rd_valid & rd_ready;
  assign push = re_d1;
  // words held in the skid plus reads still travelling through the RAM, after this edge's pop
  assign pend = {1'b0, occ} + {2'b0, ram_re} + {2'b0, re_d1} - {2'b0, pop};
  assign issue = (state_q == READ) && (left_q != '0) && (pend < 3'd2);
  assign occ_n = occ + {1'b0, push} - {1'b0, pop};
  // next state, burst address/count and the one-cycle done/clear strobes
  always_comb begin
    state_n = state_q;
    addr_n = addr_q;
    left_n = left_q;
    done_d = 1'b0;
    clr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_n = cmd_op ? READ : WRITE;
          addr_n = cmd_addr;
          left_n = {1'b0, cmd_len} + l_one;
        end
`ifdef RAM_MASTER_CLEAR_EN
        else if (clr_req && cmd_ready) begin
          state_n = CLEAR;
          clr_d = 1'b1;
        end
`endif
      end
      WRITE: if (wd_hs) begin
        addr_n = addr_q + 1'b1;
        left_n = left_q - l_one;
        state_n = left_q == l_one ? IDLE : WRITE;
        done_d = left_q == l_one;
      end
      READ: if (issue) begin
        addr_n = addr_q + 1'b1;
        left_n = left_q - l_one;
        state_n = left_q == l_one ? DRAIN : READ;
      end
      DRAIN: begin
        state_n = pend == 3'd0 ? IDLE : DRAIN;
        done_d = pend == 3'd0;
      end
`ifdef RAM_MASTER_CLEAR_EN
      CLEAR: begin
        state_n = IDLE;
        done_d = 1'b1;
      end
`endif
      default: state_n = IDLE;
    endcase
  end
  // FSM state and burst bookkeeping
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      left_q <= '0;
    end else begin
      state_q <= state_n;
      addr_q <= addr_n;
      left_q <= left_n;
    end
  // handshake and status outputs, registered from the next state
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cmd_ready <= 1'b0;
      wd_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      ram_reset <= 1'b1;
    end else begin
      cmd_ready <= state_n == IDLE;
      wd_ready <= state_n == WRITE;
      busy <= state_n != IDLE;
      done <= done_d;
      ram_reset <= clr_d;
    end
  // RAM pins: one write per accepted word, one read per issue slot
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ram_we <= 1'b0;
      ram_re <= 1'b0;
      re_d1 <= 1'b0;
      ram_w_add <= '0;
      ram_r_add <= '0;
      ram_data_in <= '0;
    end else begin
      ram_we <= wd_hs;
      ram_re <= issue;
      re_d1 <= ram_re;
      if (wd_hs) ram_w_add <= addr_q;
      if (wd_hs) ram_data_in <= wd_data;
      if (issue) ram_r_add <= addr_q;
    end
  // two-entry skid for returning read data; rd_data is the head entry
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      occ <= '0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      s1 <= '0;
    end else begin
      occ <= occ_n;
      rd_valid <= occ_n != 2'd0;
      if (push && (occ == 2'd0 || (occ == 2'd1 && pop))) rd_data <= ram_data_out;
      else if (pop && occ == 2'd2) rd_data <= s1;
      if (push && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop))) s1 <= ram_data_out;
    end
endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master: table-driven and random bursts against a word-level memory model
module tb_ram_burst_master;
  logic clk = 0;
  logic reset_n;
  logic clr_req = 0;
  logic cmd_valid = 0, cmd_op = 0, wd_valid = 0, rd_ready = 0;
  logic [3:0] cmd_addr = 0, cmd_len = 0;
  logic [7:0] wd_data = 0, ram_data_out;
  logic cmd_ready, wd_ready, rd_valid, busy, done, ram_reset, ram_we, ram_re;
  logic [7:0] rd_data, ram_data_in;
  logic [3:0] ram_w_add, ram_r_add;
  ram_burst_master dut (
    .clk(clk), .reset_n(reset_n),
`ifdef RAM_MASTER_CLEAR_EN
    .clr_req(clr_req),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .ram_reset(ram_reset), .ram_we(ram_we), .ram_re(ram_re),
    .ram_w_add(ram_w_add), .ram_r_add(ram_r_add), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );
  always #5 clk = ~clk;
  // 16x8 synchronous RAM with registered read port; reset clears contents
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      ram_data_out <= 8'h00;
    end else begin
      if (ram_we) mem[ram_w_add] <= ram_data_in;
      if (ram_re) ram_data_out <= mem[ram_r_add];
    end
  end
  int cyc = 0;
  always @(posedge clk) cyc++;
  int checks = 0, errors = 0;
  logic [7:0] ref_mem [16];
  logic [7:0] wdat [16];
  int acc_cyc[$], we_cyc[$], pop_cyc[$];
  logic [3:0] we_addr[$];
  logic [7:0] we_data[$], rq[$];
  int re_cnt, stall_re, done_cnt, done_cyc, first_re, first_rv, overlap = 0;
  logic [3:0] last_ra;
  // observe pins mid-cycle, where inputs and registered outputs are both settled
  always @(negedge clk) begin
    if (ram_we) begin we_addr.push_back(ram_w_add); we_data.push_back(ram_data_in); we_cyc.push_back(cyc); end
    if (wd_valid && wd_ready) acc_cyc.push_back(cyc);
    if (ram_re) begin
      re_cnt++;
      last_ra = ram_r_add;
      if (first_re < 0) first_re = cyc;
      if (!rd_ready) stall_re++;
    end
    if (rd_valid && first_rv < 0) first_rv = cyc;
    if (rd_valid && rd_ready) begin rq.push_back(rd_data); pop_cyc.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (ram_we && ram_re) overlap++;
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic run(input bit op, input logic [3:0] a, input logic [3:0] l, input int wm, input int rm,
                     input int nchk, input logic [31:0] d, input logic [3:0] exp_last);
    int n, idx;
    bit ok;
    n = int'(l) + 1;
    acc_cyc.delete(); we_cyc.delete(); pop_cyc.delete(); we_addr.delete(); we_data.delete(); rq.delete();
    re_cnt = 0; stall_re = 0; done_cnt = 0; done_cyc = -1; first_re = -1; first_rv = -1;
    for (int i = 0; i < 16; i++) wdat[i] = (i < nchk) ? d[31-8*i -: 8] : 8'($urandom);
    rd_ready = 0;
    cmd_op = op; cmd_addr = a; cmd_len = l; cmd_valid = 1;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    chk("cmd_accept", int'(ok), 1);
    @(negedge clk);
    chk("busy_after_cmd", int'(busy), 1);
    chk("cmd_ready_busy", int'(cmd_ready), 0);
    @(posedge clk); #1;
    if (!op) begin
      idx = 0;
      for (int t = 0; t < 400 && idx < n; t++) begin
        wd_valid = (wm == 0) ? 1'b1 : (wm == 1) ? (t % 2 == 0) : 1'($urandom_range(0, 1));
        wd_data = wdat[idx];
        @(negedge clk);
        if (wd_valid && wd_ready) idx++;
        @(posedge clk); #1;
      end
      wd_valid = 0;
    end else begin
      for (int t = 0; t < 400 && rq.size() < n; t++) begin
        rd_ready = (rm == 0) ? 1'b1 : (rm == 1) ? (t % 2 == 0) : (rm == 3) ? (t >= 5) : 1'($urandom_range(0, 1));
        @(negedge clk);
        @(posedge clk); #1;
      end
      rd_ready = 0;
    end
    for (int t = 0; t < 40 && busy; t++) begin @(posedge clk); #1; end
    @(negedge clk);
    @(posedge clk); #1;
    chk("idle_after_burst", int'(busy), 0);
    chk("cmd_ready_after", int'(cmd_ready), 1);
    chk("done_count", done_cnt, 1);
    if (!op) begin
      chk("we_count", we_addr.size(), n);
      if (we_addr.size() == n && acc_cyc.size() == n) begin
        for (int i = 0; i < n; i++) begin
          chk("w_add", int'(we_addr[i]), (int'(a) + i) % 16);
          chk("w_data", int'(we_data[i]), int'(wdat[i]));
          chk("we_after_accept", we_cyc[i], acc_cyc[i] + 1);
        end
        chk("w_last_addr", int'(we_addr[n-1]), int'(exp_last));
        chk("w_done_cycle", done_cyc, we_cyc[n-1]);
      end
      for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % 16] = wdat[i];
    end else begin
      chk("rd_count", rq.size(), n);
      chk("re_count", re_cnt, n);
      chk("rd_latency", first_rv - first_re, 2);
      chk("r_last_addr", int'(last_ra), int'(exp_last));
      if (rm == 3 && l != 0) chk("stall_re", stall_re, 2);
      if (rq.size() == n) begin
        for (int i = 0; i < n; i++) chk("rd_data_model", int'(rq[i]), int'(ref_mem[(int'(a) + i) % 16]));
        for (int i = 0; i < nchk && i < n; i++) chk("rd_data_vec", int'(rq[i]), int'(wdat[i]));
        chk("rd_done_after_pop", int'(done_cyc >= pop_cyc[n-1] && done_cyc <= pop_cyc[n-1] + 1), 1);
      end
    end
  endtask
  typedef struct {
    bit op;
    logic [3:0] addr;
    logic [3:0] len;
    int wm;
    int rm;
    int nchk;
    logic [31:0] d;
    logic [3:0] exp_last;
  } vec_t;
  vec_t vt [6];
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit rop;
    logic [3:0] ra, rl, rlast;
    bit ok;
    vt[0] = '{0, 4'd2, 4'd3, 0, 0, 4, 32'hA1A2A3A4, 4'd5};
    vt[1] = '{1, 4'd2, 4'd3, 0, 0, 4, 32'hA1A2A3A4, 4'd5};
    vt[2] = '{0, 4'd14, 4'd2, 0, 0, 3, 32'h11223300, 4'd0};
    vt[3] = '{1, 4'd14, 4'd2, 0, 0, 3, 32'h11223300, 4'd0};
    vt[4] = '{0, 4'd6, 4'd3, 1, 0, 4, 32'hC1C2C3C4, 4'd9};
    vt[5] = '{1, 4'd0, 4'd15, 0, 3, 4, 32'h3300A1A2, 4'd15};
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    reset_n = 1;
    #2 reset_n = 0;
    #1;
    chk("rst_ram_reset", int'(ram_reset), 1);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    chk("rel_cmd_ready_low", int'(cmd_ready), 0);
    @(posedge clk); #1;
    chk("rel_cmd_ready_high", int'(cmd_ready), 1);
    chk("rel_ram_reset_low", int'(ram_reset), 0);
    for (int i = 0; i < 6; i++) run(vt[i].op, vt[i].addr, vt[i].len, vt[i].wm, vt[i].rm, vt[i].nchk, vt[i].d, vt[i].exp_last);
    for (int k = 0; k < 30; k++) begin
      rop = 1'($urandom_range(0, 1));
      ra = 4'($urandom_range(0, 15));
      rl = 4'($urandom_range(0, 15));
      rlast = ra + rl;
      run(rop, ra, rl, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0, 32'h0, rlast);
    end
    // abort a long read with reset_n
    rd_ready = 1; cmd_op = 1; cmd_addr = 0; cmd_len = 15; cmd_valid = 1;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    chk("abort_cmd_accept", int'(ok), 1);
    repeat (4) @(posedge clk);
    #1 done_cnt = 0;
    chk("abort_busy_before", int'(busy), 1);
    reset_n = 0;
    #1;
    chk("abort_ram_reset", int'(ram_reset), 1);
    chk("abort_ram_re", int'(ram_re), 0);
    chk("abort_rd_valid", int'(rd_valid), 0);
    chk("abort_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    rd_ready = 0;
    @(negedge clk);
    chk("abort_rel_cmd_ready_low", int'(cmd_ready), 0);
    @(posedge clk); #1;
    chk("abort_rel_cmd_ready", int'(cmd_ready), 1);
    chk("abort_rel_ram_reset", int'(ram_reset), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    run(1, 4'd2, 4'd3, 0, 0, 4, 32'h00000000, 4'd5);
`ifdef RAM_MASTER_CLEAR_EN
    run(0, 4'd3, 4'd0, 0, 0, 1, 32'h5A000000, 4'd3);
    run(1, 4'd3, 4'd0, 0, 0, 1, 32'h5A000000, 4'd3);
    done_cnt = 0;
    clr_req = 1;
    @(posedge clk); #1;
    clr_req = 0;
    @(negedge clk);
    chk("clr_ram_reset", int'(ram_reset), 1);
    chk("clr_busy", int'(busy), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("clr_ram_reset_end", int'(ram_reset), 0);
    chk("clr_done", int'(done), 1);
    chk("clr_idle", int'(busy), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    run(1, 4'd3, 4'd0, 0, 0, 1, 32'h00000000, 4'd3);
`endif
    chk("no_we_re_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
